// File: rtl/spi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter_if
// Purpose  : Signal bundle between the round-robin SPI arbiter, its N
//            requesting peripheral drivers and the shared SPI_Master.
// Modports : master - seen from the arbiter (it owns the shared master)
//              in : req, tx_data, m_ready, m_arrived, m_dataO, m_CS
//              out: ack, done, err, rx_data, busy, m_send, m_data, cs_n
//            slave  - seen from the environment (requesters + SPI_Master)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_arbiter_if #(
   parameter int N = 4,
   parameter int W = 15
);
   // requester side
   logic [N-1:0]   req;
   logic [N*W-1:0] tx_data;
   logic [N-1:0]   ack;
   logic [N-1:0]   done;
   logic [N-1:0]   err;
   logic [W-1:0]   rx_data;
   logic           busy;
   // SPI_Master side
   logic           m_ready;
   logic           m_send;
   logic [W-1:0]   m_data;
   logic           m_arrived;
   logic [W-1:0]   m_dataO;
   logic           m_CS;
   // per-device chip selects, active-low
   logic [N-1:0]   cs_n;

   modport master (
      input  req, tx_data, m_ready, m_arrived, m_dataO, m_CS,
      output ack, done, err, rx_data, busy, m_send, m_data, cs_n
   );

   modport slave (
      output req, tx_data, m_ready, m_arrived, m_dataO, m_CS,
      input  ack, done, err, rx_data, busy, m_send, m_data, cs_n
   );
endinterface
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Purpose  : Round-robin sharing of one SPI_Master between N Pmod drivers.
//            Grants one requester at a time, loads its frame into the
//            master, routes the master chip-select to that device only,
//            and returns the received word with a done pulse. A watchdog
//            abandons a transfer (err pulse) if the master never arrives.
// Ports    : Clock, Reset (async, active-high)
//            bus (spi_arbiter_if.master) - request/ack/done/err/rx_data/busy
//            towards requesters; send/data/arrived/dataO/CS towards the
//            SPI_Master; cs_n towards the devices.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
   parameter int N       = 4,
   parameter int W       = 15,
   parameter int TIMEOUT = 4096
) (
   input  logic         Clock,
   input  logic         Reset,
   spi_arbiter_if.master bus
);
   localparam int                c_PW      = (N > 1) ? $clog2(N) : 1;
   localparam int                c_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TW-1:0]   c_TO_LAST = c_TW'(TIMEOUT - 1);
   localparam logic [c_PW-1:0]   c_LAST_ID = c_PW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_PW-1:0] r_owner;
   logic [c_PW-1:0] r_ptr;
   logic [c_TW-1:0] r_wdog;
   logic [W-1:0]    r_m_data;
   logic [W-1:0]    r_rx_data;
   logic [N-1:0]    r_ack;
   logic [N-1:0]    r_done;
   logic [N-1:0]    r_err;

   logic [c_PW-1:0] w_winner;
   logic            w_found;
   logic [c_PW-1:0] w_owner_inc;
   logic            w_grant;
   logic            w_send;
   logic            w_fin_ok;
   logic            w_fin_to;
   logic [N-1:0]    w_cs_n;

   // Round-robin pick: first active request scanning ptr, ptr+1, ... mod N.
   always_comb begin : p_rr
      int idx;
      idx      = 0;
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(r_ptr) + i) % N;
         if (!w_found && bus.req[idx]) begin
            w_found  = 1'b1;
            w_winner = c_PW'(idx);
         end
      end
   end

   // Next pointer after the current owner finishes (N need not be 2^k).
   assign w_owner_inc = (r_owner == c_LAST_ID) ? '0 : r_owner + 1'b1;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin : p_fsm
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_send      = 1'b0;
      w_fin_ok    = 1'b0;
      w_fin_to    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant     = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            // No watchdog here: a master that is never ready stalls us.
            if (bus.m_ready) begin
               w_send      = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Arrival wins over a timeout on the same cycle.
            if (bus.m_arrived) begin
               w_fin_ok    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_wdog == c_TO_LAST) begin
               w_fin_to    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_owner   <= '0;
         r_ptr     <= '0;
         r_wdog    <= '0;
         r_m_data  <= '0;
         r_rx_data <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_err     <= '0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         r_err  <= '0;
         if (w_grant) begin
            r_owner           <= w_winner;
            r_m_data          <= bus.tx_data[int'(w_winner)*W +: W];
            r_ack[w_winner]   <= 1'b1;
         end
         if (w_send) begin
            r_wdog <= '0;
         end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + 1'b1;
         end
         if (w_fin_ok) begin
            r_rx_data        <= bus.m_dataO;
            r_done[r_owner]  <= 1'b1;
            r_ptr            <= w_owner_inc;
         end
         if (w_fin_to) begin
            r_err[r_owner]   <= 1'b1;
            r_ptr            <= w_owner_inc;
         end
      end
   end

   // Chip-select demux is combinational so device CS follows the master exactly.
   always_comb begin : p_cs
      w_cs_n = '1;
      if (r_state != S_IDLE) begin
         w_cs_n[r_owner] = bus.m_CS;
      end
   end

   assign bus.cs_n    = w_cs_n;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.m_send  = w_send;
   assign bus.m_data  = r_m_data;
   assign bus.rx_data = r_rx_data;
   assign bus.ack     = r_ack;
   assign bus.done    = r_done;
   assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Purpose  : Self-checking bench for spi_arbiter (N=4, W=15, TIMEOUT=48).
//            A transaction-level model predicts the round-robin winner,
//            the captured frame, the done/err outcome and its cycle, and
//            the chip-select routing; an SPI_Master model drives the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;
   localparam int N  = 4;
   localparam int W  = 15;
   localparam int TO = 48;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_arbiter_if #(.N(N), .W(W)) bus ();

   spi_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   int            m_ptr   = 0;        // model round-robin pointer
   logic [W-1:0]  m_rx    = '0;       // model rx_data
   int            grants[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Winner: lowest set bit of the request vector rotated right by ptr.
   function automatic int rr_pick(input logic [N-1:0] rq, input int p);
      logic [2*N-1:0] dbl;
      dbl = {rq, rq} >> p;
      for (int i = 0; i < N; i++)
         if (dbl[i]) return (p + i) % N;
      return 0;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   function automatic logic [N-1:0] cs_exp(input int w, input logic cs);
      logic [N-1:0] e;
      e = '1;
      if (!cs) e[w] = 1'b0;
      return e;
   endfunction

   // One complete transaction; called while the arbiter is idle.
   // d = cycles from the m_send cycle to the m_arrived cycle; d > TO = never.
   task automatic xfer(input logic [N-1:0] rq, input int rdy_wait, input int d,
                       input logic [W-1:0] frame, input logic [W-1:0] word);
      int w;
      int lim;
      w = rr_pick(rq, m_ptr);
      for (int i = 0; i < N; i++) bus.tx_data[i*W +: W] = W'($urandom);
      bus.tx_data[w*W +: W] = frame;
      bus.req       = rq;
      bus.m_ready   = (rdy_wait == 0);
      bus.m_arrived = 1'b0;
      bus.m_CS      = 1'b1;
      cyc();
      check("ack", bus.ack, onehot(w));
      check("busy_on", bus.busy, 1);
      check("no_fin_at_ack", bus.done | bus.err, 0);
      grants.push_back(w);
      // Late changes to req/tx_data must not disturb the captured frame.
      bus.req = N'($urandom);
      for (int i = 0; i < N; i++) bus.tx_data[i*W +: W] = W'($urandom);
      for (int i = 0; i < rdy_wait; i++) begin
         bus.m_arrived = 1'($urandom);   // ignored outside the wait phase
         #1;
         check("hold_send", bus.m_send, 0);
         check("hold_err", bus.err | bus.done, 0);
         check("hold_busy", bus.busy, 1);
         cyc();
      end
      bus.m_ready   = 1'b1;
      bus.m_arrived = 1'b0;
      #1;
      check("m_send", bus.m_send, 1);
      check("m_data", bus.m_data, frame);
      check("cs_send", bus.cs_n, cs_exp(w, 1'b1));
      lim = (d <= TO) ? d : TO;
      for (int k = 1; k <= lim; k++) begin
         cyc();
         bus.m_ready   = 1'($urandom);
         bus.m_CS      = 1'($urandom);
         bus.m_arrived = (k == d);
         bus.m_dataO   = (k == d) ? word : W'($urandom);
         #1;
         check("one_send", bus.m_send, 0);
         check("wait_busy", bus.busy, 1);
         check("wait_pulses", bus.ack | bus.done | bus.err, 0);
         check("cs_route", bus.cs_n, cs_exp(w, bus.m_CS));
      end
      cyc();
      bus.m_arrived = 1'b0;
      bus.m_CS      = 1'($urandom);
      #1;
      if (d <= TO) begin
         m_rx = word;
         check("done", bus.done, onehot(w));
         check("no_err", bus.err, 0);
      end else begin
         check("err", bus.err, onehot(w));
         check("no_done", bus.done, 0);
      end
      check("rx_data", bus.rx_data, m_rx);
      check("busy_off", bus.busy, 0);
      check("cs_idle", bus.cs_n, {N{1'b1}});
      m_ptr = (w + 1) % N;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [N-1:0] rq;
      int           exp_order[6];
      rst           = 1'b1;
      bus.req       = '0;
      bus.tx_data   = '0;
      bus.m_ready   = 1'b0;
      bus.m_arrived = 1'b0;
      bus.m_dataO   = '0;
      bus.m_CS      = 1'b1;
      cyc();
      cyc();
      check("rst_busy", bus.busy, 0);
      check("rst_pulses", bus.ack | bus.done | bus.err, 0);
      check("rst_cs", bus.cs_n, {N{1'b1}});
      check("rst_rx", bus.rx_data, 0);
      check("rst_mdata", bus.m_data, 0);
      check("rst_send", bus.m_send, 0);
      #2 rst = 1'b0;

      // Idle: no request, stray arrival ignored.
      bus.m_arrived = 1'b1;
      bus.m_ready   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("idle_quiet", bus.ack | bus.done | bus.err, 0);
         check("idle_busy", bus.busy, 0);
         check("idle_send", bus.m_send, 0);
      end

      // Simultaneous requests 1011: grant order 0,1,3,0,1,3.
      grants.delete();
      for (int i = 0; i < 6; i++)
         xfer(4'b1011, 0, $urandom_range(1, TO), W'($urandom), W'($urandom));
      exp_order = '{0, 1, 3, 0, 1, 3};
      for (int i = 0; i < 6; i++) check("rr_order", grants[i], exp_order[i]);

      // Single requester, arrival 40 cycles after send.
      xfer(4'b0001, 0, 40, 15'h5a5a, 15'h1234);
      check("single_rx", bus.rx_data, 15'h1234);

      // Master not ready for 20 cycles.
      xfer(4'b0100, 20, 5, W'($urandom), W'($urandom));

      // Timeout: rx_data held, pointer advances to the next requester.
      xfer(4'b0010, 0, TO + 10, W'($urandom), W'($urandom));
      xfer(4'b1111, 0, 3, W'($urandom), W'($urandom));
      check("after_to_grant", grants[grants.size()-1], 2);

      // Arrival exactly on the timeout cycle: done wins.
      xfer(4'b1000, 1, TO, W'($urandom), 15'h7abc);

      // Randomized traffic.
      for (int i = 0; i < 30; i++) begin
         rq = N'($urandom_range(1, (1 << N) - 1));
         xfer(rq, $urandom_range(0, 3), $urandom_range(1, TO + 6),
              W'($urandom), W'($urandom));
      end

      // Reset mid-transfer: leave ptr at 2 first, then abort owner 2.
      xfer(4'b0010, 0, 4, W'($urandom), W'($urandom));
      bus.req     = 4'b0100;
      bus.m_ready = 1'b1;
      cyc();
      check("mid_ack", bus.ack, 4'b0100);
      cyc();
      cyc();
      bus.m_CS = 1'b0;
      #1;
      check("mid_cs", bus.cs_n, 4'b1011);
      #2 rst = 1'b1;
      #1;
      check("async_busy", bus.busy, 0);
      check("async_cs", bus.cs_n, {N{1'b1}});
      check("async_rx", bus.rx_data, 0);
      cyc();
      #2 rst = 1'b0;
      m_ptr = 0;
      m_rx  = '0;
      bus.m_CS = 1'b1;
      xfer(4'b1010, 0, 6, W'($urandom), W'($urandom));
      check("post_rst_grant", grants[grants.size()-1], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter that shares one SPI_Master instance between up to N Pmod peripheral drivers (e.g. ambient-light, temperature, accelerometer front-ends) on the same SCLK/MOSI/MISO bus. It grants one requester at a time, loads its frame into the master, and demultiplexes the master's chip-select onto per-device CS lines. It returns the received word and a completion pulse to the owning requester. A watchdog recovers the bus if the master never reports arrival.

## Interface
- N, 4: number of requesters (2..8).
- W, 15: SPI frame width; must match the SPI_Master width parameter.
- TIMEOUT, 4096: maximum cycles spent in S_WAIT before the transfer is abandoned (≥2).

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  N  level request per requester; held until ack.
- tx_data  in  N*W  frame per requester; slice i = tx_data[i*W +: W].
- ack  out  N  one-cycle pulse: request i granted, tx_data slice captured.
- done  out  N  one-cycle pulse: transfer for i complete, rx_data valid.
- err  out  N  one-cycle pulse: transfer for i abandoned by timeout.
- rx_data  out  W  last received word; held until next done.
- busy  out  1  high whenever state ≠ S_IDLE.
- m_ready  in  1  SPI_Master ready.
- m_send  out  1  SPI_Master send strobe.
- m_data  out  W  SPI_Master transmit word.
- m_arrived  in  1  SPI_Master arrival pulse.
- m_dataO  in  W  SPI_Master received word.
- m_CS  in  1  SPI_Master chip select, active-low.
- cs_n  out  N  per-device chip selects, active-low.

## Operation
- States: S_IDLE, S_SEND, S_WAIT. Registers: state, owner (log2 N bits), ptr (log2 N), wdog counter, m_data, rx_data, ack, done, err.
- S_IDLE: if req ≠ 0, winner = first set bit scanning ptr, ptr+1, …, wrapping mod N. On that edge: owner ← winner, m_data ← tx_data slice, ack[winner] ← 1, go S_SEND. If req = 0, stay.
- S_SEND: m_send = (state == S_SEND) & m_ready (combinational). When m_send is high, go S_WAIT and clear wdog. Otherwise stay; no timeout applies in S_SEND.
- S_WAIT: wdog increments each cycle.
  - If m_arrived: rx_data ← m_dataO, done[owner] ← 1, ptr ← (owner+1) mod N, go S_IDLE.
  - Else if wdog == TIMEOUT-1: err[owner] ← 1, rx_data unchanged, ptr ← (owner+1) mod N, go S_IDLE.
  - m_arrived takes priority over timeout in the same cycle.
- cs_n[i] = m_CS when state ≠ S_IDLE and owner == i; otherwise 1. This path is combinational.
- ack, done, err are cleared every cycle unless set as above. At most one bit of each is set, and at most one of the three vectors is nonzero in any cycle.
- req changes after ack are ignored until the arbiter returns to S_IDLE. A req dropped before being granted receives no ack.
- m_arrived outside S_WAIT is ignored.

## Timing
- Reset values: state S_IDLE, owner 0, ptr 0, wdog 0, m_data 0, rx_data 0, ack/done/err 0, busy 0, m_send 0, cs_n all 1. Reset applies immediately, including mid-transfer, and the master is not notified.
- Grant latency: req sampled at edge k in S_IDLE → ack and busy high in cycle k+1. m_send is high in cycle k+1 if m_ready is high.
- Completion: m_arrived high before edge j → done and rx_data valid in cycle j+1. State is S_IDLE in j+1, so the earliest next grant is at edge j+1 (minimum one idle cycle between transfers).
- Timeout: err fires TIMEOUT cycles after entry to S_WAIT.
- Fairness: with all N requesting continuously, each is granted once per N transfers.

## Test plan
- Single requester: N=4; req=0001, tx_data slice 0 = 15'h5a5a; master model asserts m_arrived 40 cycles after send with dataO = 15'h1234. Required: ack[0] one cycle; exactly one m_send with m_data = 5a5a; cs_n = 1110 only while m_CS is low; done[0] and rx_data = 1234; busy returns to 0.
- Simultaneous requests: req=1011 held continuously. Required: grant order 0, 1, 3, 0, 1, 3; each requester gets its own done; no overlap of cs_n lows.
- m_ready low: hold m_ready=0 for 20 cycles after ack. Required: state stays S_SEND, m_send=0, no err; the send occurs on the first m_ready=1 cycle.
- Timeout: TIMEOUT=16, master never arrives. Required: err[owner] 16 cycles after send; rx_data unchanged; ptr advances; next requester granted.
- Arrival on the timeout cycle: m_arrived coincides with wdog = TIMEOUT-1. Required: done (not err), rx_data updated.
- Reset mid-transfer: assert Reset in S_WAIT. Required: cs_n = all 1 and busy = 0 asynchronously; after release, a new req is granted normally from ptr 0.
